// File: rtl/lc3b_types.sv
// Shared write-back types: the request carried to the register-file port and
// the arbiter state encoding.
package lc3b_types;

    typedef struct packed {
        logic [2:0]  dest;
        logic [15:0] data;
        logic        ld_reg;
        logic        ld_cc;
    } lc3b_wb_req;

    typedef enum logic {NORMAL = 1'b0, FORCE = 1'b1} wb_arb_state;

    function automatic logic [7:0] dest_bit(input logic [2:0] d);
        return 8'(1) << d;
    endfunction

endpackage

// File: rtl/gencc.sv
// Condition-code generator: exactly one of n/z/p from a 16-bit value.
module gencc (
    input  logic [15:0] data,
    output logic [2:0]  nzp
);
    always_comb begin
        if (data[15])          nzp = 3'b100;
        else if (data == '0)   nzp = 3'b010;
        else                   nzp = 3'b001;
    end
endmodule

// File: rtl/mc_wb_fifo.sv
// Multicycle result FIFO. Exposes every slot's dest and occupancy so the
// arbiter can build the pending-destination mask without walking pointers.
module mc_wb_fifo
    import lc3b_types::*;
#(
    parameter int DEPTH = 2,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      push,
    input  lc3b_wb_req                push_req,
    input  logic                      pop,
    output lc3b_wb_req                head,
    output logic [CW-1:0]             count,
    output logic                      full,
    output logic                      empty,
    output logic [DEPTH-1:0][2:0]     entry_dest,
    output logic [DEPTH-1:0]          entry_vld
);
    lc3b_wb_req    mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;

    assign full  = (count == CW'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_req;
    end

    // A slot is live when its distance from the read pointer is below count.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            logic [PW-1:0] off;
            off           = PW'(i) - rd_ptr;
            entry_vld[i]  = (CW'(off) < count);
            entry_dest[i] = mem[i].dest;
        end
    end
endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the register-file/CC write port between pipeline write-back and the
// multicycle unit; pipeline wins unless a buffered result has starved too long.
module wb_port_arbiter
    import lc3b_types::*;
#(
    parameter int MC_DEPTH     = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        pipe_valid,
    input  logic        pipe_ld_reg,
    input  logic        pipe_ld_cc,
    input  logic [2:0]  pipe_dest,
    input  logic [15:0] pipe_data,
    output logic        pipe_stall,
    input  logic        mc_valid,
    output logic        mc_ready,
    input  logic [2:0]  mc_dest,
    input  logic [15:0] mc_data,
    input  logic        mc_ld_cc,
    output logic        rf_we,
    output logic [2:0]  rf_dest,
    output logic [15:0] rf_data,
    output logic        cc_we,
    output logic [2:0]  cc_nzp,
    output logic [7:0]  pending_mask
);
    localparam int CW = $clog2(MC_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    lc3b_wb_req              head, push_req;
    logic [CW-1:0]           count;
    logic                    full, empty, push;
    logic [MC_DEPTH-1:0][2:0] entry_dest;
    logic [MC_DEPTH-1:0]     entry_vld;

    wb_arb_state   state, state_nxt;
    logic [SW-1:0] starve, starve_nxt;
    logic          p_req, m_req, grant_p, grant_m, out_m;
    logic [15:0]   wdata;
    logic [2:0]    nzp_nxt;

    assign mc_ready = (count < CW'(MC_DEPTH));
    assign push     = mc_valid & ~full;
    assign push_req = '{dest: mc_dest, data: mc_data, ld_reg: 1'b1, ld_cc: mc_ld_cc};

    mc_wb_fifo #(.DEPTH(MC_DEPTH)) u_fifo (
        .clk, .reset_n, .push, .push_req, .pop(grant_m), .head, .count,
        .full, .empty, .entry_dest, .entry_vld
    );

    always_comb begin
        p_req   = pipe_valid & (pipe_ld_reg | pipe_ld_cc);
        m_req   = ~empty;
        grant_p = (state == NORMAL) & p_req;
        grant_m = (state == FORCE) ? m_req : (~p_req & m_req);
        starve_nxt = '0;
        if (state == NORMAL && m_req && !grant_m) starve_nxt = starve + 1'b1;
        state_nxt = NORMAL;
        if (state == NORMAL && starve_nxt == SW'(STARVE_LIMIT)) state_nxt = FORCE;
    end

    // pipe_stall is registered from the next state so it is high exactly in FORCE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= NORMAL;
            starve     <= '0;
            pipe_stall <= 1'b0;
        end else begin
            state      <= state_nxt;
            starve     <= starve_nxt;
            pipe_stall <= (state_nxt == FORCE);
        end
    end

    assign wdata = grant_m ? head.data : pipe_data;

    gencc u_gencc (.data(wdata), .nzp(nzp_nxt));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rf_we   <= 1'b0;
            cc_we   <= 1'b0;
            rf_dest <= '0;
            rf_data <= '0;
            cc_nzp  <= '0;
            out_m   <= 1'b0;
        end else begin
            out_m <= grant_m;
            rf_we <= 1'b0;
            cc_we <= 1'b0;
            if (grant_m) begin
                rf_we   <= head.ld_reg;
                cc_we   <= head.ld_cc;
                rf_dest <= head.dest;
                rf_data <= wdata;
                cc_nzp  <= nzp_nxt;
            end else if (grant_p) begin
                rf_we   <= pipe_ld_reg;
                cc_we   <= pipe_ld_cc;
                rf_dest <= pipe_dest;
                rf_data <= wdata;
                cc_nzp  <= nzp_nxt;
            end
        end
    end

    // An M write stays pending until the cycle after it leaves the output register.
    always_comb begin
        pending_mask = out_m ? dest_bit(rf_dest) : 8'h00;
        for (int i = 0; i < MC_DEPTH; i++)
            if (entry_vld[i]) pending_mask |= dest_bit(entry_dest[i]);
    end
endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench: directed table, hand-written corner sequences and a
// randomized run, all scored against a queue-based reference model.
module tb_wb_port_arbiter;
    localparam int MC_DEPTH = 2;
    localparam int STARVE_LIMIT = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n, pipe_valid, pipe_ld_reg, pipe_ld_cc, pipe_stall;
    logic mc_valid, mc_ready, mc_ld_cc, rf_we, cc_we;
    logic [2:0] pipe_dest, mc_dest, rf_dest, cc_nzp;
    logic [15:0] pipe_data, mc_data, rf_data;
    logic [7:0] pending_mask;

    wb_port_arbiter #(.MC_DEPTH(MC_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .pipe_valid(pipe_valid), .pipe_ld_reg(pipe_ld_reg), .pipe_ld_cc(pipe_ld_cc),
        .pipe_dest(pipe_dest), .pipe_data(pipe_data), .pipe_stall(pipe_stall),
        .mc_valid(mc_valid), .mc_ready(mc_ready), .mc_dest(mc_dest),
        .mc_data(mc_data), .mc_ld_cc(mc_ld_cc),
        .rf_we(rf_we), .rf_dest(rf_dest), .rf_data(rf_data),
        .cc_we(cc_we), .cc_nzp(cc_nzp), .pending_mask(pending_mask)
    );

    int n_cmp = 0, n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue of waiting results plus a count of lost arbitrations.
    typedef struct {logic [2:0] dest; logic [15:0] data; logic ld_cc;} ent_t;
    ent_t q[$];
    int   losses;
    bit   forced;
    logic e_we, e_cwe, e_m;
    logic [2:0] e_dest, e_nzp;
    logic [15:0] e_data;

    function automatic logic [2:0] nzp_of(input logic [15:0] v);
        if ($signed(v) < 0) return 3'b100;
        if (v == 16'd0) return 3'b010;
        return 3'b001;
    endfunction

    function automatic logic [7:0] exp_pending();
        logic [7:0] m = 8'h00;
        foreach (q[i]) m[q[i].dest] = 1'b1;
        if (e_m) m[e_dest] = 1'b1;
        return m;
    endfunction

    task automatic model_reset();
        q.delete(); losses = 0; forced = 0;
        e_we = 0; e_cwe = 0; e_m = 0; e_dest = 0; e_nzp = 0; e_data = 0;
    endtask

    // Check this cycle's handshake outputs, advance model and DUT one clock,
    // then check the registered write port (we return at posedge+1).
    task automatic cycle();
        bit p_req, m_req, gp, gm, enq;
        ent_t h;
        chk("mc_ready", mc_ready, q.size() < MC_DEPTH);
        chk("pipe_stall", pipe_stall, forced);
        p_req = pipe_valid && (pipe_ld_reg || pipe_ld_cc);
        m_req = q.size() > 0;
        gm = forced ? m_req : (!p_req && m_req);
        gp = !forced && p_req;
        enq = mc_valid && q.size() < MC_DEPTH;
        e_we = 0; e_cwe = 0; e_m = gm;
        if (gm) begin
            h = q.pop_front();
            e_we = 1; e_cwe = h.ld_cc; e_dest = h.dest; e_data = h.data; e_nzp = nzp_of(h.data);
        end else if (gp) begin
            e_we = pipe_ld_reg; e_cwe = pipe_ld_cc; e_dest = pipe_dest;
            e_data = pipe_data; e_nzp = nzp_of(pipe_data);
        end
        if (enq) q.push_back('{mc_dest, mc_data, mc_ld_cc});
        if (forced) begin
            forced = 0; losses = 0;
        end else if (m_req && !gm) begin
            losses++;
            if (losses == STARVE_LIMIT) forced = 1;
        end else losses = 0;
        @(posedge clk); #1;
        chk("rf_we", rf_we, e_we);
        chk("cc_we", cc_we, e_cwe);
        chk("rf_dest", rf_dest, e_dest);
        chk("rf_data", rf_data, e_data);
        chk("cc_nzp", cc_nzp, e_nzp);
        chk("pending_mask", pending_mask, exp_pending());
    endtask

    task automatic set_pipe(input logic v, input logic lr, input logic lc,
                            input logic [2:0] d, input logic [15:0] x);
        pipe_valid = v; pipe_ld_reg = lr; pipe_ld_cc = lc; pipe_dest = d; pipe_data = x;
    endtask

    task automatic set_mc(input logic v, input logic [2:0] d, input logic [15:0] x, input logic lc);
        mc_valid = v; mc_dest = d; mc_data = x; mc_ld_cc = lc;
    endtask

    typedef struct {
        logic pv, lr, lc; logic [2:0] dest; logic [15:0] data;
        logic x_we, x_cwe; logic [2:0] x_dest; logic [15:0] x_data; logic [2:0] x_nzp;
    } vec_t;
    vec_t tbl[7];

    initial begin
        tbl[0] = '{1,1,1,3,16'h8000, 1,1,3,16'h8000,3'b100};
        tbl[1] = '{1,1,0,2,16'h0000, 1,0,2,16'h0000,3'b010};
        tbl[2] = '{1,0,1,7,16'h0001, 0,1,7,16'h0001,3'b001};
        tbl[3] = '{1,1,1,0,16'h7fff, 1,1,0,16'h7fff,3'b001};
        tbl[4] = '{1,1,1,4,16'hffff, 1,1,4,16'hffff,3'b100};
        tbl[5] = '{0,1,1,5,16'h1234, 0,0,4,16'hffff,3'b100};
        tbl[6] = '{1,0,0,6,16'h5555, 0,0,4,16'hffff,3'b100};

        set_pipe(0,0,0,0,0); set_mc(0,0,0,0);
        reset_n = 0; model_reset();
        #12;
        chk("reset rf_we", rf_we, 0);
        chk("reset mc_ready", mc_ready, 1);
        chk("reset pending", pending_mask, 0);
        chk("reset cc_nzp", cc_nzp, 0);
        reset_n = 1;
        @(posedge clk); #1;

        // Directed pipeline-only vectors.
        foreach (tbl[i]) begin
            set_pipe(tbl[i].pv, tbl[i].lr, tbl[i].lc, tbl[i].dest, tbl[i].data);
            cycle();
            chk("tbl rf_we", rf_we, tbl[i].x_we);
            chk("tbl cc_we", cc_we, tbl[i].x_cwe);
            chk("tbl rf_dest", rf_dest, tbl[i].x_dest);
            chk("tbl rf_data", rf_data, tbl[i].x_data);
            chk("tbl cc_nzp", cc_nzp, tbl[i].x_nzp);
        end
        set_pipe(0,0,0,0,0);

        // Multicycle-only write: pending in cycles 1-2, commit shown in cycle 2.
        set_mc(1, 5, 16'h0000, 1);
        cycle();
        chk("mc pending c1", pending_mask, 8'h20);
        set_mc(0,0,0,0);
        cycle();
        chk("mc rf_we c2", rf_we, 1);
        chk("mc rf_dest c2", rf_dest, 5);
        chk("mc cc_nzp c2", cc_nzp, 3'b010);
        chk("mc pending c2", pending_mask, 8'h20);
        cycle();
        chk("mc pending c3", pending_mask, 8'h00);

        // Starvation: pipeline busy, one mc entry at head from cycle 1.
        set_mc(1, 6, 16'h00aa, 0);
        set_pipe(1,1,0,1,16'h1000);
        cycle();
        set_mc(0,0,0,0);
        for (int k = 1; k <= 4; k++) begin
            set_pipe(1,1,0,1,16'h1000 + 16'(k));
            cycle();
            chk("starve pipe wins", rf_data, 16'h1000 + 16'(k));
        end
        set_pipe(1,1,0,2,16'h2005);
        chk("starve stall c5", pipe_stall, 1);
        cycle();
        chk("starve mc c6 dest", rf_dest, 6);
        chk("starve mc c6 data", rf_data, 16'h00aa);
        chk("starve stall c6", pipe_stall, 0);
        cycle();
        chk("starve held pipe c7", rf_data, 16'h2005);

        // FIFO full: mc offered three cycles while the pipeline is busy.
        set_pipe(1,1,1,3,16'h0042);
        set_mc(1, 1, 16'h0011, 0); cycle();
        set_mc(1, 2, 16'h0022, 0); cycle();
        set_mc(1, 4, 16'h0044, 1);
        chk("full ready c2", mc_ready, 0);
        cycle(); cycle(); cycle();
        chk("full stall c5", pipe_stall, 1);
        chk("full+deq ready c5", mc_ready, 0);
        cycle();
        chk("after force ready c6", mc_ready, 1);
        cycle();
        set_mc(0,0,0,0);
        chk("third accepted", pending_mask[4], 1);
        // Full in NORMAL with head granted in the same cycle.
        set_pipe(0,0,0,0,0);
        set_mc(1, 7, 16'h0077, 0);
        chk("full+deq ready", mc_ready, 0);
        cycle();
        set_mc(0,0,0,0);
        chk("count1 ready", mc_ready, 1);
        chk("no enqueue", pending_mask[7], 0);
        repeat (4) cycle();

        // Reset with two entries buffered, asserted mid-cycle.
        set_pipe(1,1,0,0,16'h0001);
        set_mc(1, 3, 16'h0333, 0); cycle();
        set_mc(1, 6, 16'h0666, 0); cycle();
        #2 reset_n = 0;
        #1;
        chk("rst rf_we", rf_we, 0);
        chk("rst cc_we", cc_we, 0);
        chk("rst rf_dest", rf_dest, 0);
        chk("rst rf_data", rf_data, 0);
        chk("rst cc_nzp", cc_nzp, 0);
        chk("rst stall", pipe_stall, 0);
        chk("rst pending", pending_mask, 0);
        chk("rst mc_ready", mc_ready, 1);
        model_reset();
        set_pipe(0,0,0,0,0); set_mc(0,0,0,0);
        #2 reset_n = 1;
        @(posedge clk); #1;
        cycle(); cycle();
        chk("no write after reset", rf_we, 0);

        // Randomized traffic; the pipeline holds while stalled, mc holds until accepted.
        for (int n = 0; n < 3000; n++) begin
            if (!pipe_stall) begin
                logic [15:0] d;
                d = $urandom();
                case ($urandom_range(0, 5)) 0: d = 16'h0000; 1: d = 16'h8000; default: ; endcase
                set_pipe($urandom_range(0, 99) < 70, 1'($urandom()), 1'($urandom()),
                         3'($urandom()), d);
            end
            if (!(mc_valid && !mc_ready))
                set_mc($urandom_range(0, 99) < 35, 3'($urandom()), 16'($urandom()), 1'($urandom()));
            cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
